// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - five-phase instruction sequencer with run/stop, halt and memory-wait timeout
module phase_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
  input  logic             halt,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic [4:0]       phase,
  output logic             mem_req,
  output logic             ir_we,
  output logic             wb_en,
  output logic             running,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_P1     = 3'd1;
  localparam logic [2:0] S_P2     = 3'd2;
  localparam logic [2:0] S_P3     = 3'd3;
  localparam logic [2:0] S_P4     = 3'd4;
  localparam logic [2:0] S_P5     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic [2:0]       state_q, state_d;
  logic             exec_q, exec_d;
  logic             stop_pend_q, stop_pend_d;
  logic             halt_pend_q, halt_pend_d;
  logic             macc_q, macc_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [4:0]       phase_q, phase_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic exec_edge;
  logic waiting;
  logic timeout;
  logic in_instr;

  // Strobes decoded straight from the current state; ir_we also needs mem_ready
  always_comb begin
    exec_edge = exec & ~exec_q;
    in_instr  = (state_q >= S_P1) && (state_q <= S_P5);
    waiting   = (state_q == S_P1) || ((state_q == S_P4) && macc_q);
    timeout   = waiting && !mem_ready && (wait_cnt_q == WAIT_LIM);
    mem_req   = waiting;
    ir_we     = (state_q == S_P1) && mem_ready;
    wb_en     = (state_q == S_P5);
  end

  // Next-state logic for the sequencer and its bookkeeping flags
  always_comb begin
    state_d     = state_q;
    exec_d      = exec;
    stop_pend_d = stop_pend_q;
    halt_pend_d = halt_pend_q;
    macc_d      = macc_q;
    wait_cnt_d  = wait_cnt_q;
    count_d     = count_q;

    // A run/stop press mid-instruction only arms the stop; the instruction finishes
    if (in_instr && exec_edge) stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (exec_edge) begin
          state_d    = S_P1;
          wait_cnt_d = 8'd0;
        end
      end
      S_P1, S_P4: begin
        if (state_q == S_P4 && !macc_q) begin
          state_d = S_P5;
        end else if (mem_ready) begin
          // Completion on the limit cycle still wins over the timeout
          state_d = (state_q == S_P1) ? S_P2 : S_P5;
        end else if (timeout) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_P2: state_d = S_P3;
      S_P3: begin
        halt_pend_d = halt;
        macc_d      = mem_access;
        wait_cnt_d  = 8'd0;
        state_d     = S_P4;
      end
      S_P5: begin
        count_d = count_q + CNT_W'(1);
        if (halt_pend_q) begin
          state_d = S_HALTED;
        end else if (stop_pend_q || exec_edge) begin
          // A press during P5 itself stops right after this instruction
          state_d     = S_IDLE;
          stop_pend_d = 1'b0;
        end else begin
          state_d    = S_P1;
          wait_cnt_d = 8'd0;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Registered status outputs derived from the state being entered
  always_comb begin
    phase_d   = 5'd0;
    running_d = (state_d >= S_P1) && (state_d <= S_P5);
    halted_d  = (state_d == S_HALTED);
    error_d   = (state_d == S_ERROR);
    case (state_d)
      S_P1:    phase_d = 5'b00001;
      S_P2:    phase_d = 5'b00010;
      S_P3:    phase_d = 5'b00100;
      S_P4:    phase_d = 5'b01000;
      S_P5:    phase_d = 5'b10000;
      default: phase_d = 5'b00000;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      exec_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      halt_pend_q <= 1'b0;
      macc_q      <= 1'b0;
      wait_cnt_q  <= 8'd0;
      phase_q     <= 5'd0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      exec_q      <= exec_d;
      stop_pend_q <= stop_pend_d;
      halt_pend_q <= halt_pend_d;
      macc_q      <= macc_d;
      wait_cnt_q  <= wait_cnt_d;
      phase_q     <= phase_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      error_q     <= error_d;
      count_q     <= count_d;
    end
  end

  assign phase       = phase_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign error       = error_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - randomized and directed checks of phase_sequencer against a reference model
module tb_phase_sequencer;

  localparam int CW = 16;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          exec = 1'b0;
  logic          halt = 1'b0;
  logic          mem_access = 1'b0;
  logic          mem_ready = 1'b0;
  logic [4:0]    phase;
  logic          mem_req, ir_we, wb_en, running, halted, error;
  logic [CW-1:0] instr_count;

  phase_sequencer #(.CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .exec(exec), .halt(halt),
    .mem_access(mem_access), .mem_ready(mem_ready), .phase(phase),
    .mem_req(mem_req), .ir_we(ir_we), .wb_en(wb_en), .running(running),
    .halted(halted), .error(error), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad = 0;

  // reference model: mode 0 stopped, 1 executing, 2 halted, 3 errored
  int m_mode, m_ph, m_low, m_cnt;
  bit m_prev, m_stop, m_hp, m_macc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_ph = 0; m_low = 0; m_cnt = 0;
    m_prev = 0; m_stop = 0; m_hp = 0; m_macc = 0;
  endtask

  task automatic m_step(input bit e, input bit h, input bit m, input bit r);
    bit edge_seen;
    edge_seen = e && !m_prev;
    m_prev = e;
    if (m_mode == 0) begin
      if (edge_seen) begin m_mode = 1; m_ph = 1; m_low = 0; end
    end else if (m_mode == 1) begin
      if (edge_seen) m_stop = 1;
      if (m_ph == 1 || (m_ph == 4 && m_macc)) begin
        if (r) m_ph = (m_ph == 1) ? 2 : 5;
        else if (m_low >= MW) m_mode = 3;
        else m_low++;
      end else if (m_ph == 2) begin
        m_ph = 3;
      end else if (m_ph == 3) begin
        m_hp = h; m_macc = m; m_low = 0; m_ph = 4;
      end else if (m_ph == 4) begin
        m_ph = 5;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (m_hp) m_mode = 2;
        else if (m_stop) begin m_mode = 0; m_stop = 0; end
        else begin m_ph = 1; m_low = 0; end
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0] eph;
    bit act;
    act = (m_mode == 1);
    eph = 5'd0;
    if (act) eph[m_ph-1] = 1'b1;
    chk("phase", 32'(phase), 32'(eph));
    chk("mem_req", 32'(mem_req), 32'(act && (m_ph == 1 || (m_ph == 4 && m_macc))));
    chk("ir_we", 32'(ir_we), 32'(act && m_ph == 1 && mem_ready));
    chk("wb_en", 32'(wb_en), 32'(act && m_ph == 5));
    chk("running", 32'(running), 32'(act));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("error", 32'(error), 32'(m_mode == 3));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
  endtask

  // drive one cycle's inputs just after negedge, check, then advance the model at posedge
  task automatic cycle(input bit e, input bit h, input bit m, input bit r);
    exec = e; halt = h; mem_access = m; mem_ready = r;
    #1;
    check_outputs();
    @(posedge clock);
    m_step(e, h, m, r);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; exec = 1'b0; halt = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
    m_reset();
    @(negedge clock);
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bit e;
    int rp;
    m_reset();
    @(negedge clock);

    // straight-line run: three instructions in fifteen cycles
    do_reset();
    cycle(1, 0, 0, 1);
    chk("first_p1", 32'(phase), 32'h01);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 1);
    chk("cnt_after_15", 32'(instr_count), 32'd3);
    chk("back_to_p1", 32'(phase), 32'h01);

    // memory instruction with three wait cycles in P4
    do_reset();
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk("p4_wait_phase", 32'(phase), 32'h08);
      cycle(0, 0, 0, 0);
    end
    chk("p4_still", 32'(phase), 32'h08);
    cycle(0, 0, 0, 1);
    chk("p5_after_wait", 32'(phase), 32'h10);
    chk("wb_in_p5", 32'(wb_en), 32'd1);
    cycle(0, 0, 0, 1);
    chk("mem_instr_count", 32'(instr_count), 32'd1);
    chk("eight_cycles", 32'(phase), 32'h01);

    // halt retired by the second instruction
    do_reset();
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", 32'(instr_count), 32'd2);
    chk("halt_running", 32'(running), 32'd0);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk("halt_sticky_phase", 32'(phase), 32'd0);

    // stop requested in P2, restart keeps the count
    do_reset();
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_count", 32'(instr_count), 32'd1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("stop_idle", 32'(phase), 32'd0);
    cycle(1, 0, 0, 1);
    chk("restart_p1", 32'(phase), 32'h01);
    chk("restart_count", 32'(instr_count), 32'd1);

    // fetch timeout and limit-cycle completion
    do_reset();
    cycle(1, 0, 0, 1);
    for (int i = 0; i < MW + 1; i++) cycle(0, 0, 0, 0);
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_memreq", 32'(mem_req), 32'd0);
    do_reset();
    cycle(1, 0, 0, 1);
    for (int i = 0; i < MW; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("limit_ok_phase", 32'(phase), 32'h02);
    chk("limit_ok_error", 32'(error), 32'd0);

    // asynchronous reset in the middle of a waiting P4
    do_reset();
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    exec = 1'b0; mem_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_memreq", 32'(mem_req), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_count", 32'(instr_count), 32'd0);
    m_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    chk("arst_idle", 32'(phase), 32'd0);

    // randomized segments
    for (int s = 0; s < 24; s++) begin
      rp = (s % 3 == 0) ? 35 : 85;
      do_reset();
      e = 1'b0;
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 99) < 8) e = ~e;
        cycle(e, $urandom_range(0, 99) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < rp);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multi-cycle phase sequencer for the SIMPLE processor core. It steps each instruction through five phases: fetch, decode, execute, memory, writeback. It gates the per-phase enables that the decode controller's RegWrite/MemtoReg/PCSrc outputs are qualified with, and it owns run, stop, halt and memory-wait handling.

Parameters:
CNT_W, 16, width of retired-instruction counter
MAX_WAIT, 15, max consecutive mem_ready-low cycles tolerated in a memory-waiting phase before ERROR (1..255)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
exec  input  1  run/stop button level from the board (already debounced); rising edge = command
halt  input  1  HLT decoded from the current instruction; valid during P3
mem_access  input  1  current instruction is a load or store; valid during P3/P4
mem_ready  input  1  memory completes the current access this cycle
phase  output  5  one-hot phase: bit0 P1 fetch ... bit4 P5 writeback; 0 when not running
mem_req  output  1  memory access request
ir_we  output  1  instruction register load strobe
wb_en  output  1  qualifies register-file write and PC update (P5)
running  output  1  sequencer is executing instructions
halted  output  1  HLT retired; sticky
error  output  1  memory-wait timeout; sticky
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- States: IDLE, P1, P2, P3, P4, P5, HALTED, ERROR. Encoding is free; phase output is one-hot and registered.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0; instr_count=0.
  - exec_q=0, stop_pend=0, halt_pend=0, wait_cnt=0.
  - Reset asserted mid-instruction aborts it with no further strobes.
- Edge detect: exec_q registers exec. exec_edge = exec & ~exec_q, combinational.
- IDLE: on exec_edge, go to P1 next cycle and set running=1. Otherwise stay.
- P1 (fetch):
  - mem_req=1.
  - If mem_ready=1: ir_we=1 this cycle, go to P2.
  - If mem_ready=0: stay and increment wait_cnt.
- P2: always go to P3 after one cycle.
- P3:
  - Sample halt into halt_pend.
  - Sample mem_access into a held flag used by P4.
  - Go to P4.
- P4:
  - If held mem_access=0: no mem_req, one cycle, go to P5.
  - If held mem_access=1: mem_req=1 and wait on mem_ready exactly as in P1.
- P5:
  - wb_en=1 for exactly one cycle.
  - instr_count increments on exit.
  - Exit priority: halt_pend -> HALTED; else stop_pend -> IDLE (running=0, stop_pend cleared); else P1.
- exec_edge in P1..P5 sets stop_pend. The current instruction always completes. A second edge while stop_pend=1 has no further effect.
- wait_cnt:
  - Cleared on entry to P1 and to P4.
  - If wait_cnt reaches MAX_WAIT while mem_ready is still 0, go to ERROR next cycle.
  - mem_ready=1 in the same cycle takes priority over the timeout.
- HALTED: running=0, halted=1, phase=0. Ignores exec. Left only by reset.
- ERROR: running=0, error=1, phase=0, no strobes. Left only by reset.
- Latency:
  - With mem_ready tied 1, an instruction occupies exactly 5 cycles.
  - Back-to-back instructions have no bubble (P5 -> P1).
  - First P1 is the cycle after the clock edge on which exec_edge is seen.
- Output timing: mem_req, ir_we and wb_en are decoded from the current state (plus mem_ready for ir_we), with no extra register stage.
- At most one of ir_we and wb_en is high in any cycle. ir_we is never high outside P1.

Test Plan:
- Reset, then exec pulse, mem_ready=1, no halt -> phase walks 00001,00010,00100,01000,10000,00001...; ir_we high in every P1; wb_en high in every P5; instr_count=3 after 15 cycles.
- Instruction with mem_access=1 and mem_ready low 3 cycles in P4 -> P4 lasts 4 cycles, mem_req high throughout, wb_en exactly once, instruction takes 8 cycles.
- halt=1 in P3 of the 2nd instruction -> P4 and P5 complete; instr_count=2; halted=1, running=0, phase=0; later exec pulses have no effect.
- exec pulse during P2 of an instruction -> instruction finishes through P5, then IDLE with running=0; a new exec pulse restarts at P1 with instr_count preserved.
- MAX_WAIT=4, mem_ready held 0 in P1 -> ERROR after the 4-cycle limit; error=1, mem_req drops. Repeat with mem_ready=1 on the limit cycle -> no ERROR, advances to P2.
- reset driven low asynchronously mid-P4 -> all outputs 0 immediately; counter 0; after release, IDLE until the next exec edge.
